// File: rtl/alu_result_packer.sv
// Packs successive W-bit ALU results (LS nibble first) into an NIBBLES*W word.
// Latency: last nibble accepted at edge n -> word_valid after edge n (1 cycle).
// Backpressure: in_ready drops only when the final nibble has nowhere to go.
module alu_result_packer #(
   parameter int W       = 4,
   parameter int NIBBLES = 4,
   parameter int CW      = $clog2(NIBBLES + 1),
   parameter int OW      = W * NIBBLES
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  alu_data,
   input  logic          alu_cout,
   input  logic [2:0]    alu_sel,
   input  logic          flush,
   output logic          word_valid,
   input  logic          word_ready,
   output logic [OW-1:0] word,
   output logic [CW-1:0] word_len,
   output logic          word_carry,
   output logic          word_carry_any,
   output logic [2:0]    word_sel,
   output logic          sel_mismatch
);

   localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

   // assembly state
   logic [OW-1:0] r_acc;
   logic [CW-1:0] r_cnt;
   logic          r_carry_any;
   logic          r_carry_last;
   logic [2:0]    r_sel0;
   logic          r_mismatch;

   // assembly state including the nibble accepted this cycle
   logic [OW-1:0] w_acc_nx;
   logic          w_carry_any_nx;
   logic          w_carry_last_nx;
   logic [2:0]    w_sel0_nx;
   logic          w_mismatch_nx;
   logic [CW-1:0] w_len;

   logic w_out_free;
   logic w_accept;
   logic w_complete;
   logic w_flush;
   logic w_xfer;
   logic w_drain;

   assign w_out_free = !word_valid || word_ready;
   assign in_ready   = !((r_cnt == LAST) && !w_out_free);
   assign w_accept   = in_valid && in_ready;
   assign w_drain    = word_valid && word_ready;
   // in_ready already guarantees the output slot is free on a completing accept
   assign w_complete = w_accept && (r_cnt == LAST);
   // a flush with nothing buffered and nothing arriving produces no word
   assign w_flush    = flush && w_out_free && ((r_cnt != '0) || w_accept);
   assign w_xfer     = w_complete || w_flush;
   assign w_len      = r_cnt + CW'(w_accept);

   // Merge the incoming nibble into the assembly state; a new word starts clean,
   // so nibbles above cnt are always zero and a flushed word is zero-padded.
   always_comb begin
      w_acc_nx        = r_acc;
      w_carry_any_nx  = r_carry_any;
      w_carry_last_nx = r_carry_last;
      w_sel0_nx       = r_sel0;
      w_mismatch_nx   = r_mismatch;
      if (w_accept) begin
         w_carry_last_nx = alu_cout;
         if (r_cnt == '0) begin
            w_acc_nx       = '0;
            w_carry_any_nx = alu_cout;
            w_sel0_nx      = alu_sel;
            w_mismatch_nx  = 1'b0;
         end else begin
            w_carry_any_nx = r_carry_any | alu_cout;
            w_mismatch_nx  = r_mismatch | (alu_sel != r_sel0);
         end
         for (int k = 0; k < NIBBLES; k++) begin
            if (r_cnt == CW'(k)) begin
               w_acc_nx[W*k +: W] = alu_data;
            end
         end
      end
   end

   // Assembly registers: advance on accept, restart after handing a word over
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc        <= '0;
         r_cnt        <= '0;
         r_carry_any  <= 1'b0;
         r_carry_last <= 1'b0;
         r_sel0       <= '0;
         r_mismatch   <= 1'b0;
      end else begin
         r_acc        <= w_acc_nx;
         r_carry_any  <= w_carry_any_nx;
         r_carry_last <= w_carry_last_nx;
         r_sel0       <= w_sel0_nx;
         r_mismatch   <= w_mismatch_nx;
         if (w_xfer) begin
            r_cnt <= '0;
         end else if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // Output registers: load on transfer (zero-bubble with drain), else hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_valid     <= 1'b0;
         word           <= '0;
         word_len       <= '0;
         word_carry     <= 1'b0;
         word_carry_any <= 1'b0;
         word_sel       <= '0;
         sel_mismatch   <= 1'b0;
      end else if (w_xfer) begin
         word_valid     <= 1'b1;
         word           <= w_acc_nx;
         word_len       <= w_len;
         word_carry     <= w_carry_last_nx;
         word_carry_any <= w_carry_any_nx;
         word_sel       <= w_sel0_nx;
         sel_mismatch   <= w_mismatch_nx;
      end else if (w_drain) begin
         word_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_result_packer.sv
// Directed bench for alu_result_packer (W=4, NIBBLES=4).
// Inputs driven 1 time unit after the rising edge; outputs sampled there too.
// Expected values are hand-computed constants.
module tb_alu_result_packer;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_data;
   logic        alu_cout;
   logic [2:0]  alu_sel;
   logic        flush;
   logic        word_valid;
   logic        word_ready;
   logic [15:0] word;
   logic [2:0]  word_len;
   logic        word_carry;
   logic        word_carry_any;
   logic [2:0]  word_sel;
   logic        sel_mismatch;

   int n_chk;
   int n_err;

   alu_result_packer #(.W(4), .NIBBLES(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .alu_data       (alu_data),
      .alu_cout       (alu_cout),
      .alu_sel        (alu_sel),
      .flush          (flush),
      .word_valid     (word_valid),
      .word_ready     (word_ready),
      .word           (word),
      .word_len       (word_len),
      .word_carry     (word_carry),
      .word_carry_any (word_carry_any),
      .word_sel       (word_sel),
      .sel_mismatch   (sel_mismatch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] d, input logic c, input logic [2:0] s);
      in_valid = v;
      alu_data = d;
      alu_cout = c;
      alu_sel  = s;
   endtask

   task automatic chk_word(input string tag, input logic [15:0] w, input logic [2:0] len,
                           input logic cl, input logic ca, input logic [2:0] s, input logic mm);
      chk({tag, ".valid"},    {31'd0, word_valid},     32'd1);
      chk({tag, ".word"},     {16'd0, word},           {16'd0, w});
      chk({tag, ".len"},      {29'd0, word_len},       {29'd0, len});
      chk({tag, ".carry"},    {31'd0, word_carry},     {31'd0, cl});
      chk({tag, ".carryany"}, {31'd0, word_carry_any}, {31'd0, ca});
      chk({tag, ".sel"},      {29'd0, word_sel},       {29'd0, s});
      chk({tag, ".mismatch"}, {31'd0, sel_mismatch},   {31'd0, mm});
   endtask

   initial begin
      n_chk      = 0;
      n_err      = 0;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      alu_data   = '0;
      alu_cout   = 1'b0;
      alu_sel    = '0;
      flush      = 1'b0;
      word_ready = 1'b0;

      // reset state
      #3;
      chk("rst.valid",    {31'd0, word_valid}, 32'd0);
      chk("rst.word",     {16'd0, word},       32'd0);
      chk("rst.len",      {29'd0, word_len},   32'd0);
      chk("rst.in_ready", {31'd0, in_ready},   32'd1);
      #4 rst_n = 1'b1;
      tick();

      // basic full word, consumer ready
      word_ready = 1'b1;
      drive(1'b1, 4'h3, 1'b0, 3'd5); tick();
      drive(1'b1, 4'hA, 1'b1, 3'd5); tick();
      drive(1'b1, 4'h0, 1'b0, 3'd5); tick();
      chk("basic.notyet", {31'd0, word_valid}, 32'd0);
      drive(1'b1, 4'hF, 1'b0, 3'd5); tick();
      drive(1'b0, 4'h0, 1'b0, 3'd0);
      chk_word("basic", 16'hF0A3, 3'd4, 1'b0, 1'b1, 3'd5, 1'b0);
      tick();
      chk("basic.drained", {31'd0, word_valid}, 32'd0);
      chk("basic.hold",    {16'd0, word},       32'h0000F0A3);

      // backpressure: stalled word, 3 more accepted, 4th held off
      word_ready = 1'b0;
      drive(1'b1, 4'h1, 1'b0, 3'd0); tick();
      drive(1'b1, 4'h2, 1'b0, 3'd0); tick();
      drive(1'b1, 4'h3, 1'b0, 3'd0); tick();
      drive(1'b1, 4'h4, 1'b0, 3'd0); tick();
      chk_word("bp.first", 16'h4321, 3'd4, 1'b0, 1'b0, 3'd0, 1'b0);
      drive(1'b1, 4'h5, 1'b0, 3'd0);
      chk("bp.rdy0", {31'd0, in_ready}, 32'd1); tick();
      drive(1'b1, 4'h6, 1'b0, 3'd0);
      chk("bp.rdy1", {31'd0, in_ready}, 32'd1); tick();
      drive(1'b1, 4'h7, 1'b0, 3'd0);
      chk("bp.rdy2", {31'd0, in_ready}, 32'd1); tick();
      drive(1'b1, 4'h8, 1'b1, 3'd0);
      chk("bp.rdy3_low", {31'd0, in_ready}, 32'd0);
      tick();
      chk("bp.still_low", {31'd0, in_ready}, 32'd0);
      chk_word("bp.stable", 16'h4321, 3'd4, 1'b0, 1'b0, 3'd0, 1'b0);
      word_ready = 1'b1;
      #1;
      chk("bp.rdy_release", {31'd0, in_ready}, 32'd1);
      tick();
      drive(1'b0, 4'h0, 1'b0, 3'd0);
      chk_word("bp.second", 16'h8765, 3'd4, 1'b1, 1'b1, 3'd0, 1'b0);
      tick();
      chk("bp.drained", {31'd0, word_valid}, 32'd0);

      // flush of a partial word
      drive(1'b1, 4'h7, 1'b1, 3'd2); tick();
      drive(1'b1, 4'hC, 1'b0, 3'd2); tick();
      drive(1'b0, 4'h0, 1'b0, 3'd0);
      flush = 1'b1; tick();
      flush = 1'b0;
      chk_word("flush2", 16'h00C7, 3'd2, 1'b0, 1'b1, 3'd2, 1'b0);
      tick();
      chk("flush2.drained", {31'd0, word_valid}, 32'd0);
      // flush with nothing buffered: ignored
      flush = 1'b1; tick();
      flush = 1'b0;
      chk("flush_empty", {31'd0, word_valid}, 32'd0);
      // flush together with an accept at cnt 0 includes that nibble
      drive(1'b1, 4'h9, 1'b0, 3'd1);
      flush = 1'b1; tick();
      flush = 1'b0;
      drive(1'b0, 4'h0, 1'b0, 3'd0);
      chk_word("flush1", 16'h0009, 3'd1, 1'b0, 1'b0, 3'd1, 1'b0);
      tick();

      // select mismatch, then a consistent word
      drive(1'b1, 4'h1, 1'b0, 3'd3); tick();
      drive(1'b1, 4'h2, 1'b0, 3'd3); tick();
      drive(1'b1, 4'h3, 1'b0, 3'd6); tick();
      drive(1'b1, 4'h4, 1'b0, 3'd3); tick();
      chk_word("mm.bad", 16'h4321, 3'd4, 1'b0, 1'b0, 3'd3, 1'b1);
      drive(1'b1, 4'h5, 1'b0, 3'd1); tick();
      drive(1'b1, 4'h6, 1'b0, 3'd1); tick();
      drive(1'b1, 4'h7, 1'b0, 3'd1); tick();
      drive(1'b1, 4'h8, 1'b0, 3'd1); tick();
      drive(1'b0, 4'h0, 1'b0, 3'd0);
      chk_word("mm.good", 16'h8765, 3'd4, 1'b0, 1'b0, 3'd1, 1'b0);
      tick();

      // async reset mid-word with a pending output word
      word_ready = 1'b0;
      drive(1'b1, 4'hB, 1'b1, 3'd4); tick();
      drive(1'b1, 4'hB, 1'b1, 3'd4); tick();
      drive(1'b1, 4'hB, 1'b1, 3'd4); tick();
      drive(1'b1, 4'hB, 1'b1, 3'd4); tick();
      drive(1'b1, 4'h9, 1'b0, 3'd4); tick();
      drive(1'b1, 4'hA, 1'b0, 3'd4); tick();
      drive(1'b0, 4'h0, 1'b0, 3'd0);
      chk("ar.pre_valid", {31'd0, word_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar.valid",    {31'd0, word_valid},     32'd0);
      chk("ar.word",     {16'd0, word},           32'd0);
      chk("ar.len",      {29'd0, word_len},       32'd0);
      chk("ar.carry",    {31'd0, word_carry},     32'd0);
      chk("ar.carryany", {31'd0, word_carry_any}, 32'd0);
      chk("ar.sel",      {29'd0, word_sel},       32'd0);
      chk("ar.mismatch", {31'd0, sel_mismatch},   32'd0);
      chk("ar.in_ready", {31'd0, in_ready},       32'd1);
      #2 rst_n = 1'b1;
      tick();
      word_ready = 1'b1;
      drive(1'b1, 4'h5, 1'b0, 3'd1); tick();
      drive(1'b1, 4'h6, 1'b0, 3'd1); tick();
      drive(1'b1, 4'h7, 1'b0, 3'd1); tick();
      chk("ar.partial", {31'd0, word_valid}, 32'd0);
      drive(1'b1, 4'h8, 1'b0, 3'd1); tick();
      drive(1'b0, 4'h0, 1'b0, 3'd0);
      chk_word("ar.clean", 16'h8765, 3'd4, 1'b0, 1'b0, 3'd1, 1'b0);
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/alu_result_packer.md
Name: alu_result_packer

Overview:
Downstream stage of the 4-bit ALU. Captures successive ALU results (data_out, cout, select) under a valid/ready handshake and packs NIBBLES of them, least significant first, into one wide word. Tracks the carry flags and checks op consistency. The packed word is presented on a registered output with its own valid/ready handshake, so the ALU can keep running while the consumer stalls.

Parameters:
W, 4, width of one ALU result (matches ALU data_out)
NIBBLES, 4, results per packed word (>=2); output width OW = W*NIBBLES
CW, $clog2(NIBBLES+1), width of count/length fields

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  ALU result valid this cycle
in_ready  out  1  packer accepts result this cycle
alu_data  in  W  ALU data_out
alu_cout  in  1  ALU cout
alu_sel  in  3  ALU select used for this result
flush  in  1  emit partially filled word
word_valid  out  1  packed word valid
word_ready  in  1  consumer accepts word
word  out  OW  packed word; nibble k at bits [W*k+W-1 : W*k]
word_len  out  CW  number of valid nibbles in word (1..NIBBLES)
word_carry  out  1  cout of last accepted nibble in word
word_carry_any  out  1  OR of all couts in word
word_sel  out  3  select of first nibble in word
sel_mismatch  out  1  some nibble's select differed from first nibble's

Behaviour:
- Two register sets: assembly (acc, cnt, carry_any, carry_last, sel0, mismatch) and output (word_* , word_valid).
- Accept = in_valid & in_ready. Drain = word_valid & word_ready. Out_free = !word_valid | word_ready.
- in_ready = !(cnt == NIBBLES-1 & !out_free). Ready is high in all other states, including right after reset.
- On accept at cnt: acc[nibble cnt] <= alu_data; carry_any |= alu_cout; carry_last <= alu_cout.
- At cnt==0 the accepted nibble sets sel0 <= alu_sel and clears mismatch and carry_any (set to alu_cout). Upper nibbles of acc are cleared.
- At cnt>0, mismatch |= (alu_sel != sel0).
- Completion: an accept at cnt==NIBBLES-1 transfers the assembly state, including the current nibble, to the output registers in the same edge. It sets word_valid=1, word_len=NIBBLES, and resets cnt to 0.
- Flush: flush=1 with out_free and (cnt>0 or accept) transfers the partial word. Upper nibbles are zero-padded and word_len = cnt + accept.
  - A nibble accepted in the same cycle is included before flushing.
  - Flush with cnt==0 and no accept: ignored, no word produced.
  - Flush while !out_free: held off. Flush must be re-asserted; it is not latched.
- Drain with no new transfer: word_valid <= 0, other output fields hold. Drain and transfer in the same cycle: new word loads, word_valid stays 1 (zero-bubble).
- Output fields change only on transfer; they are stable while word_valid & !word_ready.
- Latency: the last nibble accepted at edge n gives word_valid=1 after edge n. Throughput: one nibble per cycle sustained when word_ready=1.
- Reset (async, any time, including mid-word or while word_valid): cnt=0, acc=0, word_valid=0, word=0, word_len=0, word_carry=0, word_carry_any=0, word_sel=0, sel_mismatch=0. Any partial word is discarded.
- Outputs are all registered; in_ready is combinational from cnt, word_valid and word_ready.

Test Plan:
- Reset, then four accepts {data,cout,sel} = {3,0,5},{A,1,5},{0,0,5},{F,0,5} with word_ready=1 -> next cycle word=16'hF0A3, word_len=4, word_carry=0, word_carry_any=1, word_sel=5, sel_mismatch=0.
- Fill a word with word_ready=0, then present 3 more nibbles -> 3 accepted, in_ready=0 on the 4th. Raise word_ready -> first word drains and second word (4th nibble) loads in the same edge, word_valid stays 1.
- Accept 2 nibbles {7,1,2},{C,0,2}, then flush=1 -> word=16'h00C7, word_len=2, word_carry=0, word_carry_any=1. Flush at cnt=0 with no accept -> no word_valid.
- Nibbles with sel 3,3,6,3 -> sel_mismatch=1, word_sel=3. The next word with constant sel=1 -> sel_mismatch=0.
- Assert rst_n=0 asynchronously (mid-clock) after 2 accepted nibbles and with word_valid=1 -> all outputs 0 immediately, in_ready=1. The following 4 nibbles form a clean word with no stale data.
